// File: rtl/fifo_pkg.sv
// Shared definitions for the dual-clock FIFO controllers: pointer code
// conversions and synchroniser defaults used by both clock domains.
package fifo_pkg;

  localparam int SYNC_STAGES_DEFAULT = 2;

  // Conversion functions work on a zero-extended container, so any pointer
  // up to PTR_FN_W bits converts correctly; callers size-cast in and out.
  localparam int PTR_FN_W = 32;

  function automatic logic [PTR_FN_W-1:0] bin2gray(input logic [PTR_FN_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_FN_W-1:0] gray2bin(input logic [PTR_FN_W-1:0] g);
    logic [PTR_FN_W-1:0] b;
    b[PTR_FN_W-1] = g[PTR_FN_W-1];
    for (int i = PTR_FN_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_ptr_sync.sv
// N-stage async-reset flop synchroniser for Gray-coded pointers crossing
// between the FIFO clock domains.
module fifo_ptr_sync
  import fifo_pkg::*;
#(
  parameter int W      = 11,
  parameter int STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_stage [STAGES];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < STAGES; s++) begin
        r_stage[s] <= '0;
      end
    end else begin
      r_stage[0] <= i_d;
      for (int s = 1; s < STAGES; s++) begin
        r_stage[s] <= r_stage[s-1];
      end
    end
  end

  assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of the dual-clock FIFO: drives the RAM write port,
// keeps binary/Gray write pointers and derives full/afull/count/overflow.
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int WIDTH        = 18,
  parameter int ADDR_W       = 10,
  parameter int AFULL_THRESH = 1020,
  parameter int SYNC_STAGES  = SYNC_STAGES_DEFAULT
) (
  input  logic              wclk_int,
  input  logic              rst_int,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W:0]   rptr_gray,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [WIDTH-1:0]  mem_data,
  output logic              mem_we,
  output logic [ADDR_W:0]   wptr_gray,
  output logic              full,
  output logic              afull,
  output logic [ADDR_W:0]   wr_count,
  output logic              overflow
);

  localparam int PW = ADDR_W + 1;
  localparam logic [PW-1:0] AFULL_CMP = PW'(AFULL_THRESH);

  logic [PW-1:0] r_wbin;
  logic [PW-1:0] r_wgray;
  logic [PW-1:0] r_wr_count;
  logic          r_full;
  logic          r_afull;
  logic          r_overflow;

  logic          w_accept;
  logic [PW-1:0] w_rq;
  logic [PW-1:0] w_rbin;
  logic [PW-1:0] w_wbin_next;
  logic [PW-1:0] w_wgray_next;
  logic [PW-1:0] w_full_cmp;
  logic [PW-1:0] w_count_next;
  logic          w_full_next;
  logic          w_afull_next;

  fifo_ptr_sync #(
    .W      (PW),
    .STAGES (SYNC_STAGES)
  ) u_rptr_sync (
    .i_clk   (wclk_int),
    .i_rst_n (rst_int),
    .i_d     (rptr_gray),
    .o_q     (w_rq)
  );

  // Gating with rst_int keeps the RAM write port quiet during reset even if
  // the user is still pushing.
  assign w_accept = wr_en & ~r_full & rst_int;

  always_comb begin
    w_wbin_next  = r_wbin + PW'(w_accept);
    w_wgray_next = PW'(bin2gray(PTR_FN_W'(w_wbin_next)));
    w_rbin       = PW'(gray2bin(PTR_FN_W'(w_rq)));
    // Full when the write pointer is exactly one lap ahead of the synced
    // read pointer: the top two Gray bits differ, the rest match.
    w_full_cmp   = {~w_rq[ADDR_W:ADDR_W-1], w_rq[ADDR_W-2:0]};
    w_full_next  = (w_wgray_next == w_full_cmp);
    w_count_next = w_wbin_next - w_rbin;
    w_afull_next = (w_count_next >= AFULL_CMP);
  end

  always_ff @(posedge wclk_int or negedge rst_int) begin
    if (!rst_int) begin
      r_wbin     <= '0;
      r_wgray    <= '0;
      r_wr_count <= '0;
      r_full     <= 1'b0;
      r_afull    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_wbin     <= w_wbin_next;
      r_wgray    <= w_wgray_next;
      r_wr_count <= w_count_next;
      r_full     <= w_full_next;
      r_afull    <= w_afull_next;
      r_overflow <= wr_en & r_full;
    end
  end

  assign mem_we    = w_accept;
  assign mem_waddr = r_wbin[ADDR_W-1:0];
  assign mem_data  = wdata;
  assign wptr_gray = r_wgray;
  assign full      = r_full;
  assign afull     = r_afull;
  assign wr_count  = r_wr_count;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl at depth 16, afull threshold 14, 2 sync stages.
`timescale 1ns/100ps
module tb_fifo_wr_ctrl;

  localparam int WIDTH        = 18;
  localparam int ADDR_W       = 4;
  localparam int AFULL_THRESH = 14;
  localparam int SYNC_STAGES  = 2;

  logic              wclk_int  = 1'b0;
  logic              rst_int   = 1'b0;
  logic              wr_en     = 1'b0;
  logic [WIDTH-1:0]  wdata     = '0;
  logic [ADDR_W:0]   rptr_gray = '0;
  logic [ADDR_W-1:0] mem_waddr;
  logic [WIDTH-1:0]  mem_data;
  logic              mem_we;
  logic [ADDR_W:0]   wptr_gray;
  logic              full;
  logic              afull;
  logic [ADDR_W:0]   wr_count;
  logic              overflow;

  int n_checks = 0;
  int n_fails  = 0;

  fifo_wr_ctrl #(
    .WIDTH        (WIDTH),
    .ADDR_W       (ADDR_W),
    .AFULL_THRESH (AFULL_THRESH),
    .SYNC_STAGES  (SYNC_STAGES)
  ) dut (
    .wclk_int  (wclk_int),
    .rst_int   (rst_int),
    .wr_en     (wr_en),
    .wdata     (wdata),
    .rptr_gray (rptr_gray),
    .mem_waddr (mem_waddr),
    .mem_data  (mem_data),
    .mem_we    (mem_we),
    .wptr_gray (wptr_gray),
    .full      (full),
    .afull     (afull),
    .wr_count  (wr_count),
    .overflow  (overflow)
  );

  // clock / watchdog
  always #5 wclk_int = ~wclk_int;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] g5(input int b);
    logic [4:0] x;
    x = 5'(b);
    return x ^ (x >> 1);
  endfunction

  // drivers: inputs change at negedge, registered outputs sampled 1ns after posedge
  task automatic drive(input logic en, input logic [WIDTH-1:0] d);
    @(negedge wclk_int);
    wr_en = en;
    wdata = d;
    #1;
  endtask

  task automatic tick();
    @(posedge wclk_int);
    #1;
  endtask

  task automatic do_reset();
    @(negedge wclk_int);
    rst_int = 1'b0;
    wr_en   = 1'b0;
    repeat (2) @(negedge wclk_int);
    rst_int = 1'b1;
  endtask

  initial begin
    int exp_cnt;
    logic [4:0] prev_g;

    // 1: reset state, then fill 16 words
    wr_en = 1'b1;
    wdata = 18'h3;
    #12;
    check_val("rst_mem_we",   32'(mem_we),    32'd0);
    check_val("rst_full",     32'(full),      32'd0);
    check_val("rst_afull",    32'(afull),     32'd0);
    check_val("rst_count",    32'(wr_count),  32'd0);
    check_val("rst_overflow", 32'(overflow),  32'd0);
    check_val("rst_wgray",    32'(wptr_gray), 32'd0);
    @(negedge wclk_int);
    rst_int = 1'b1;
    wr_en   = 1'b0;

    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 18'(i));
      check_val("fill_we",   32'(mem_we),    32'd1);
      check_val("fill_addr", 32'(mem_waddr), 32'(i));
      check_val("fill_data", 32'(mem_data),  32'(i));
      tick();
      check_val("fill_count", 32'(wr_count),  32'(i + 1));
      check_val("fill_afull", 32'(afull),     32'((i + 1) >= 14));
      check_val("fill_full",  32'(full),      32'((i + 1) == 16));
      check_val("fill_wgray", 32'(wptr_gray), 32'(g5(i + 1)));
    end
    check_val("fill_wgray_final", 32'(wptr_gray), 32'h18);

    // 2: pushes while full
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 18'h2AAAA);
      check_val("ovf_we", 32'(mem_we), 32'd0);
      tick();
      check_val("ovf_pulse", 32'(overflow),  32'd1);
      check_val("ovf_wgray", 32'(wptr_gray), 32'h18);
      check_val("ovf_count", 32'(wr_count),  32'd16);
    end
    drive(1'b0, '0);
    tick();
    check_val("ovf_clear", 32'(overflow), 32'd0);

    // 3: one read crosses the synchroniser
    drive(1'b0, '0);
    rptr_gray = 5'b00001;
    tick();
    check_val("rd_full_e1", 32'(full), 32'd1);
    tick();
    check_val("rd_full_e2", 32'(full), 32'd1);
    tick();
    check_val("rd_full_e3",  32'(full),     32'd0);
    check_val("rd_count_e3", 32'(wr_count), 32'd15);
    check_val("rd_afull_e3", 32'(afull),    32'd1);

    // 6: push into the freed slot refills
    drive(1'b1, 18'h12345);
    check_val("refill_we",   32'(mem_we),    32'd1);
    check_val("refill_addr", 32'(mem_waddr), 32'd0);
    check_val("refill_data", 32'(mem_data),  32'h12345);
    tick();
    check_val("refill_full",  32'(full),      32'd1);
    check_val("refill_count", 32'(wr_count),  32'd16);
    check_val("refill_wgray", 32'(wptr_gray), 32'h19);
    drive(1'b0, '0);

    // 4: streaming with the reader 2 words behind
    rptr_gray = '0;
    do_reset();
    prev_g = '0;
    for (int c = 0; c < 40; c++) begin
      drive(1'b1, 18'(100 + c));
      rptr_gray = g5((c >= 2) ? c - 2 : 0);
      check_val("strm_we",   32'(mem_we),    32'd1);
      check_val("strm_addr", 32'(mem_waddr), 32'(c % 16));
      tick();
      exp_cnt = (c + 1) - ((c >= 4) ? c - 4 : 0);
      check_val("strm_full",  32'(full),      32'd0);
      check_val("strm_count", 32'(wr_count),  32'(exp_cnt));
      check_val("strm_msb",   32'(wptr_gray[4]), 32'(((c + 1) >> 4) & 1));
      check_val("strm_wgray", 32'(wptr_gray), 32'(g5(c + 1)));
      check_val("strm_hamm",  32'($countones(wptr_gray ^ prev_g)), 32'd1);
      prev_g = wptr_gray;
    end
    drive(1'b0, '0);

    // 5: async reset mid-burst
    rptr_gray = '0;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      drive(1'b1, 18'(c));
      tick();
    end
    check_val("mid_count_pre", 32'(wr_count), 32'd8);
    #2;
    rst_int = 1'b0;
    #0.5;
    check_val("mid_wgray_rst", 32'(wptr_gray), 32'd0);
    check_val("mid_count_rst", 32'(wr_count),  32'd0);
    check_val("mid_full_rst",  32'(full),      32'd0);
    check_val("mid_we_rst",    32'(mem_we),    32'd0);
    #0.5;
    rst_int = 1'b1;
    drive(1'b1, 18'h30001);
    check_val("mid_addr_post", 32'(mem_waddr), 32'd0);
    check_val("mid_we_post",   32'(mem_we),    32'd1);
    tick();
    check_val("mid_count_post", 32'(wr_count),  32'd1);
    check_val("mid_wgray_post", 32'(wptr_gray), 32'd1);
    drive(1'b0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
